// File: rtl/timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : timer_slave
// Brief    : Memory-mapped 64-bit machine timer with prescaler, compare
//            interrupt and a high-word read shadow for tear-free reads.
// Revision : 1.0  initial release
// ============================================================================
module timer_slave #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ram_ce,
    input  logic             ram_we,
    input  logic [3:0]       ram_sel,
    input  logic [WIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0] ram_data_in,
    output logic [WIDTH-1:0] ram_data,
    output logic             ram_rvalid,
    output logic             irq_timer
);

    localparam logic [2:0] c_mtime_lo = 3'd0;
    localparam logic [2:0] c_mtime_hi = 3'd1;
    localparam logic [2:0] c_cmp_lo   = 3'd2;
    localparam logic [2:0] c_cmp_hi   = 3'd3;
    localparam logic [2:0] c_ctrl     = 3'd4;
    localparam logic [2:0] c_presc    = 3'd5;

    logic [63:0] mtime_q,  mtime_d;
    logic [63:0] cmp_q,    cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [15:0] pcnt_q,   pcnt_d;
    logic [15:0] presc_q,  presc_d;
    logic [1:0]  ctrl_q,   ctrl_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q,    irq_d;

    logic        w_sel, w_wr, w_rd, w_tick;
    logic [2:0]  w_idx;
    logic [31:0] w_rmux, w_presc_wr;
    logic        w_unused_ok;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Address bits [1:0] are don't-care; only word offsets decode.
    assign w_unused_ok = &{1'b0, ram_addr[1:0]};

    always_comb begin
        w_sel      = ram_ce && (ram_addr[31:5] == BASE_ADDR[31:5]);
        w_wr       = w_sel && ram_we;
        w_rd       = w_sel && !ram_we;
        w_idx      = ram_addr[4:2];
        w_tick     = ctrl_q[0] && (pcnt_q == presc_q);
        w_presc_wr = merge({16'd0, presc_q}, ram_data_in, ram_sel);

        case (w_idx)
            c_mtime_lo: w_rmux = mtime_q[31:0];
            c_mtime_hi: w_rmux = shadow_q;
            c_cmp_lo:   w_rmux = cmp_q[31:0];
            c_cmp_hi:   w_rmux = cmp_q[63:32];
            c_ctrl:     w_rmux = {30'd0, ctrl_q};
            c_presc:    w_rmux = {16'd0, presc_q};
            default:    w_rmux = 32'd0;
        endcase
    end

    always_comb begin
        mtime_d  = mtime_q + {63'd0, w_tick};
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        pcnt_d   = pcnt_q;
        presc_d  = presc_q;
        ctrl_d   = ctrl_q;
        rdata_d  = rdata_q;
        rvalid_d = w_rd;
        irq_d    = ctrl_q[1] && (mtime_q >= cmp_q);

        if (ctrl_q[0]) pcnt_d = w_tick ? 16'd0 : pcnt_q + 16'd1;

        if (w_wr) begin
            // A write to either mtime half suppresses this cycle's tick entirely.
            case (w_idx)
                c_mtime_lo: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], ram_data_in, ram_sel)};
                c_mtime_hi: mtime_d = {merge(mtime_q[63:32], ram_data_in, ram_sel), mtime_q[31:0]};
                c_cmp_lo:   cmp_d   = {cmp_q[63:32], merge(cmp_q[31:0], ram_data_in, ram_sel)};
                c_cmp_hi:   cmp_d   = {merge(cmp_q[63:32], ram_data_in, ram_sel), cmp_q[31:0]};
                c_ctrl:     if (ram_sel[0]) ctrl_d = ram_data_in[1:0];
                c_presc: begin
                    presc_d = w_presc_wr[15:0];
                    pcnt_d  = 16'd0;
                end
                default: ;
            endcase
        end

        if (w_rd) begin
            rdata_d = w_rmux;
            if (w_idx == c_mtime_lo) shadow_d = mtime_q[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q  <= 64'd0;
            cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q <= 32'd0;
            pcnt_q   <= 16'd0;
            presc_q  <= 16'd0;
            ctrl_q   <= 2'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
        end
    end

    assign ram_data   = rdata_q;
    assign ram_rvalid = rvalid_q;
    assign irq_timer  = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_slave
// Brief    : Self-checking bench for timer_slave; read responses are matched
//            against a queue of expected values filled when each read is issued.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ce = 1'b0;
    logic        ram_we = 1'b0;
    logic [3:0]  ram_sel = 4'h0;
    logic [31:0] ram_addr = 32'd0;
    logic [31:0] ram_data_in = 32'd0;
    logic [31:0] ram_data;
    logic        ram_rvalid;
    logic        irq_timer;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] tol;
        int          due;
    } rd_t;

    rd_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    timer_slave #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_sel(ram_sel), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data(ram_data), .ram_rvalid(ram_rvalid), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each issued read is owed exactly one rvalid on the next cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            rd_t e;
            logic [31:0] diff;
            e = sb.pop_front();
            diff = (ram_data > e.exp) ? ram_data - e.exp : e.exp - ram_data;
            checks++;
            if (ram_rvalid !== 1'b1 || diff > e.tol) begin
                errors++;
                $display("FAIL %s: rvalid=%0b data=%08h, required rvalid=1 data=%08h (+/-%0d)",
                         e.name, ram_rvalid, ram_data, e.exp, e.tol);
            end
        end else if (ram_rvalid) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: rvalid=1 data=%08h at cycle %0d, required rvalid=0",
                     ram_data, cyc);
        end
    end

    // All bus tasks start and end at a falling edge.
    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        ram_ce = 1'b1; ram_we = 1'b1; ram_sel = be;
        ram_addr = BASE + off; ram_data_in = data;
        @(negedge clk);
        ram_ce = 1'b0; ram_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] exp,
                      input logic [31:0] tol, input string name);
        rd_t e;
        ram_ce = 1'b1; ram_we = 1'b0; ram_sel = 4'hF; ram_addr = BASE + off;
        e.name = name; e.exp = exp; e.tol = tol; e.due = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        ram_ce = 1'b0;
    endtask

    task automatic chk_irq(input logic exp, input string name);
        checks++;
        if (irq_timer !== exp) begin
            errors++;
            $display("FAIL %s: irq_timer=%0b, required %0b", name, irq_timer, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ram_data !== 32'd0 || ram_rvalid !== 1'b0 || irq_timer !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%08h rvalid=%0b irq=%0b, required 0/0/0",
                     ram_data, ram_rvalid, irq_timer);
        end
        rst = 1'b0;
        rd(32'h08, 32'hFFFF_FFFF, 0, "reset_cmp_lo");
        rd(32'h0C, 32'hFFFF_FFFF, 0, "reset_cmp_hi");
        @(negedge clk);
        checks++;
        if (ram_rvalid !== 1'b0 || ram_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL data_hold: rvalid=%0b data=%08h, required 0/FFFFFFFF", ram_rvalid, ram_data);
        end
        rd(32'h00, 32'd0, 0, "reset_mtime_lo");
        rd(32'h04, 32'd0, 0, "reset_mtime_hi");
        rd(32'h10, 32'd0, 0, "reset_ctrl");
        rd(32'h14, 32'd0, 0, "reset_presc");
        chk_irq(1'b0, "reset_irq");
    endtask

    task automatic test_prescaler();
        wr(32'h14, 32'd3, 4'hF);
        wr(32'h10, 32'd1, 4'hF);
        repeat (40) @(negedge clk);
        rd(32'h00, 32'd10, 1, "presc3_mtime");
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        wr(32'h14, 32'd0, 4'hF);
        wr(32'h10, 32'd1, 4'hF);
        repeat (20) @(negedge clk);
        rd(32'h00, 32'd20, 0, "presc0_mtime");
        wr(32'h10, 32'd0, 4'hF);
        repeat (5) @(negedge clk);
        rd(32'h00, 32'd22, 0, "disabled_hold");
    endtask

    task automatic test_carry_shadow();
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h14, 32'd0, 4'hF);
        wr(32'h10, 32'd1, 4'hF);
        repeat (3) @(negedge clk);
        rd(32'h00, 32'd2, 0, "carry_lo");
        rd(32'h04, 32'd1, 0, "carry_hi");
        // Shadow must survive a carry between the LO and HI reads.
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h00, 32'hFFFF_FFFF, 4'hF);
        wr(32'h04, 32'd5, 4'hF);
        wr(32'h10, 32'd1, 4'hF);
        rd(32'h00, 32'hFFFF_FFFF, 0, "shadow_lo");
        rd(32'h04, 32'd5, 0, "shadow_hi_pre_carry");
        rd(32'h04, 32'd5, 0, "shadow_hi_repeat");
        rd(32'h00, 32'd2, 0, "shadow_lo_after");
        rd(32'h04, 32'd6, 0, "shadow_hi_after");
        // A write to HI in a tick cycle blocks the LO increment.
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h00, 32'h10, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h10, 32'd1, 4'hF);
        wr(32'h04, 32'd7, 4'hF);
        rd(32'h00, 32'h10, 0, "write_priority_lo");
        rd(32'h04, 32'd7, 0, "write_priority_hi");
    endtask

    task automatic test_irq();
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h00, 32'd0, 4'hF);
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h08, 32'd100, 4'hF);
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h14, 32'd0, 4'hF);
        chk_irq(1'b0, "irq_disabled");
        wr(32'h10, 32'd3, 4'hF);
        repeat (100) @(negedge clk);
        chk_irq(1'b0, "irq_before_match");
        @(negedge clk);
        chk_irq(1'b1, "irq_at_match");
        rd(32'h08, 32'd100, 0, "irq_cmp_read");
        chk_irq(1'b1, "irq_read_no_effect");
        wr(32'h0C, 32'd1, 4'hF);
        chk_irq(1'b1, "irq_lag_after_cmp_write");
        @(negedge clk);
        chk_irq(1'b0, "irq_drop_cmp_hi");
        wr(32'h0C, 32'd0, 4'hF);
        @(negedge clk);
        chk_irq(1'b1, "irq_rearm");
        wr(32'h10, 32'd1, 4'hF);
        chk_irq(1'b1, "irq_lag_after_ctrl");
        @(negedge clk);
        chk_irq(1'b0, "irq_drop_irq_en");
    endtask

    task automatic test_bytes_decode();
        wr(32'h10, 32'd0, 4'hF);
        wr(32'h00, 32'h55, 4'hF);
        wr(32'h08, 32'hFFFF_FFFF, 4'hF);
        wr(32'h08, 32'h0000_00AB, 4'b0001);
        rd(32'h08, 32'hFFFF_FFAB, 0, "byte_lane_cmp_lo");
        rd(32'h0A, 32'hFFFF_FFAB, 0, "addr_low_bits_ignored");
        wr(32'h20, 32'h1234, 4'hF);
        wr(32'h30, 32'd3, 4'hF);
        wr(32'h18, 32'hDEAD_BEEF, 4'hF);
        ram_ce = 1'b0; ram_we = 1'b1; ram_sel = 4'hF;
        ram_addr = BASE + 32'h10; ram_data_in = 32'd3;
        @(negedge clk);
        ram_we = 1'b0;
        ram_ce = 1'b1; ram_addr = BASE + 32'h20;
        @(negedge clk);
        ram_ce = 1'b0;
        @(negedge clk);
        rd(32'h00, 32'h55, 0, "unselected_mtime");
        rd(32'h10, 32'd0, 0, "unselected_ctrl");
        rd(32'h18, 32'd0, 0, "reserved_reads_zero");
        rd(32'h14, 32'd0, 0, "presc_unchanged");
    endtask

    task automatic test_reset_abort();
        wr(32'h14, 32'h0000_ABCD, 4'hF);
        wr(32'h10, 32'd3, 4'hF);
        ram_ce = 1'b1; ram_we = 1'b0; ram_addr = BASE;
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ram_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL abort_rvalid: rvalid=%0b in reset, required 0", ram_rvalid);
            end
        end
        ram_ce = 1'b0;
        rst = 1'b0;
        rd(32'h00, 32'd0, 0, "abort_mtime_lo");
        rd(32'h04, 32'd0, 0, "abort_shadow");
        rd(32'h08, 32'hFFFF_FFFF, 0, "abort_cmp_lo");
        rd(32'h0C, 32'hFFFF_FFFF, 0, "abort_cmp_hi");
        rd(32'h10, 32'd0, 0, "abort_ctrl");
        rd(32'h14, 32'd0, 0, "abort_presc");
        chk_irq(1'b0, "abort_irq");
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_carry_shadow();
        test_irq();
        test_bytes_decode();
        test_reset_abort();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: %0d reads unanswered, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
